dac_serial_tx: RTL and testbench

//  Output end of the filter chain: takes each filtered sample y and its one-cycle valid strobe rx_2.

---
 rtl/dac_serial_tx.sv | 175 +++++++++++++++++
 tb/tb_dac_serial_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_serial_tx.sv
// Offset-binary converter and SPI-style frame serializer feeding a serial DAC.
// Define DAC_SAT_EN for x2 gain with saturation; otherwise the code is a plain truncation.
module dac_serial_tx #(
  parameter int unsigned cant_bits = 25,
  parameter int unsigned DAC_BITS  = 12,
  parameter int unsigned CLK_DIV   = 4,
  parameter logic [3:0]  CTRL      = 4'b0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [cant_bits-1:0] y,
  input  logic                 rx_2,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 sdata,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int unsigned FRAME_W = 4 + DAC_BITS;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [DAC_BITS-1:0] pend_code_q, pend_code_d;
  logic                pend_full_q, pend_full_d;
  logic [FRAME_W-1:0]  shreg_q, shreg_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                phase_q, phase_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                sdata_q, sdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic                consume;
  logic [DAC_BITS-1:0] code_c;

  // Sample to DAC code conversion
`ifdef DAC_SAT_EN
  logic [DAC_BITS-1:0] sat_s;
  logic                unused_lsb_c;

  assign unused_lsb_c = ^y[cant_bits-DAC_BITS-2:0];

  always_comb begin
    sat_s = y[cant_bits-2 -: DAC_BITS];
    if (y[cant_bits-1] != y[cant_bits-2]) begin
      sat_s = y[cant_bits-1] ? {1'b1, {(DAC_BITS-1){1'b0}}} : {1'b0, {(DAC_BITS-1){1'b1}}};
    end
    code_c = {~sat_s[DAC_BITS-1], sat_s[DAC_BITS-2:0]};
  end
`else
  logic unused_lsb_c;

  assign unused_lsb_c = ^y[cant_bits-DAC_BITS-1:0];

  always_comb begin
    code_c = {~y[cant_bits-1], y[cant_bits-2 -: (DAC_BITS-1)]};
  end
`endif

  // Next-state, pending buffer and registered-output logic
  always_comb begin
    state_d     = state_q;
    pend_code_d = pend_code_q;
    pend_full_d = pend_full_q;
    shreg_d     = shreg_q;
    bit_d       = bit_q;
    div_d       = div_q;
    phase_d     = phase_q;
    ovr_d       = ovr_q;
    consume     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_full_q) state_d = LOAD;
      end
      LOAD: begin
        consume = 1'b1;
        shreg_d = {CTRL, pend_code_q};
        bit_d   = BIT_LAST;
        div_d   = '0;
        phase_d = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          phase_d = ~phase_q;
          // high->low transition: advance to the next bit or finish the frame
          if (phase_q) begin
            if (bit_q == '0) begin
              state_d = DONE;
            end else begin
              shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
              bit_d   = bit_q - 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE: begin
        if (div_q == DIV_LAST) begin
          state_d = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A strobe in LOAD refills the slot being consumed, so it is not an overrun
    if (rx_2) begin
      if (pend_full_q && !consume) ovr_d = 1'b1;
      pend_code_d = code_c;
      pend_full_d = 1'b1;
    end else if (consume) begin
      pend_full_d = 1'b0;
    end

    sclk_d  = (state_d == SHIFT) && phase_d;
    cs_n_d  = (state_d != SHIFT);
    sdata_d = (state_d == SHIFT) && shreg_d[FRAME_W-1];
    busy_d  = (state_d != IDLE) || pend_full_d;
    done_d  = (state_d == DONE) && (div_d == DIV_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_code_q <= '0;
      pend_full_q <= 1'b0;
      shreg_q     <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      phase_q     <= 1'b0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      sdata_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_code_q <= pend_code_d;
      pend_full_q <= pend_full_d;
      shreg_q     <= shreg_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      sdata_q     <= sdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign sdata   = sdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_dac_serial_tx.sv
// Scoreboard bench for dac_serial_tx: two instances (CTRL=0 and CTRL=3) share stimulus,
// a negedge monitor deserialises each frame and checks it against queued expectations.
module tb_dac_serial_tx;

  localparam int unsigned CB      = 25;
  localparam int unsigned DB      = 12;
  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned FW      = 16;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          rx_2 = 1'b0;
  logic [CB-1:0] y    = '0;

  logic sclk0, cs_n0, sdata0, busy0, done0, ovr0;
  logic sclk1, cs_n1, sdata1, busy1, done1, ovr1;

  dac_serial_tx #(.cant_bits(CB), .DAC_BITS(DB), .CLK_DIV(CLK_DIV), .CTRL(4'b0000)) dut (
    .clk(clk), .rst(rst), .y(y), .rx_2(rx_2),
    .sclk(sclk0), .cs_n(cs_n0), .sdata(sdata0), .busy(busy0), .done(done0), .overrun(ovr0)
  );

  dac_serial_tx #(.cant_bits(CB), .DAC_BITS(DB), .CLK_DIV(CLK_DIV), .CTRL(4'b0011)) dut_ctrl (
    .clk(clk), .rst(rst), .y(y), .rx_2(rx_2),
    .sclk(sclk1), .cs_n(cs_n1), .sdata(sdata1), .busy(busy1), .done(done1), .overrun(ovr1)
  );

  always #5 clk = ~clk;

  // Directed samples and their hand-computed 12-bit codes
  localparam logic [CB-1:0] VEC_Y [6] = '{25'h0800000, 25'h0000000, 25'h1FFFFFF,
                                          25'h1000000, 25'h0200000, 25'h1234567};
`ifdef DAC_SAT_EN
  localparam logic [DB-1:0] VEC_CODE [6] = '{12'hFFF, 12'h800, 12'h7FF, 12'h000, 12'hA00, 12'h000};
`else
  localparam logic [DB-1:0] VEC_CODE [6] = '{12'hC00, 12'h800, 12'h7FF, 12'h000, 12'h900, 12'h11A};
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;
  int          frames0 = 0;
  logic [FW-1:0] q0 [$];
  logic [FW-1:0] q1 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input int idx, input bit expect_it);
    @(negedge clk);
    y    = VEC_Y[idx];
    rx_2 = 1'b1;
    if (expect_it) begin
      q0.push_back({4'h0, VEC_CODE[idx]});
      q1.push_back({4'h3, VEC_CODE[idx]});
    end
    @(negedge clk);
    rx_2 = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy0 || busy1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy0 || busy1), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: deserialise frames on sclk rises, check length, data and done timing
  logic          prev_sclk [2];
  logic          prev_cs   [2];
  logic [FW-1:0] sh        [2];
  int            nbits     [2];
  int            lowlen    [2];
  int            since_rise[2];

  always @(negedge clk) begin
    logic          sc [2];
    logic          cs [2];
    logic          sd [2];
    logic          dn [2];
    logic [FW-1:0] exp_f;
    int            qsz;
    sc[0] = sclk0;  sc[1] = sclk1;
    cs[0] = cs_n0;  cs[1] = cs_n1;
    sd[0] = sdata0; sd[1] = sdata1;
    dn[0] = done0;  dn[1] = done1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        prev_sclk[k]  = 1'b0;
        prev_cs[k]    = 1'b1;
        sh[k]         = '0;
        nbits[k]      = 0;
        lowlen[k]     = 0;
        since_rise[k] = 1000;
      end else begin
        if (!cs[k]) begin
          lowlen[k]++;
          if (sc[k] && !prev_sclk[k]) begin
            sh[k] = {sh[k][FW-2:0], sd[k]};
            nbits[k]++;
          end
        end
        if (cs[k] && !prev_cs[k]) begin
          since_rise[k] = 0;
          if (k == 0) frames0++;
          check($sformatf("frame_bits%0d", k), 32'(nbits[k]), 32'(FW));
          check($sformatf("cs_low_len%0d", k), 32'(lowlen[k]), 32'(32 * CLK_DIV));
          qsz = (k == 0) ? q0.size() : q1.size();
          if (qsz == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame%0d: got 0x%04h required no frame", k, sh[k]);
          end else begin
            if (k == 0) exp_f = q0.pop_front();
            else        exp_f = q1.pop_front();
            check($sformatf("frame_data%0d", k), 32'(sh[k]), 32'(exp_f));
          end
          nbits[k]  = 0;
          lowlen[k] = 0;
        end else if (since_rise[k] < 1000) begin
          since_rise[k]++;
        end
        if (dn[k]) check($sformatf("done_timing%0d", k), 32'(since_rise[k]), 32'(CLK_DIV - 1));
        prev_sclk[k] = sc[k];
        prev_cs[k]   = cs[k];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int frames_before;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_sclk",    32'(sclk0),  32'd0);
    check("rst_cs_n",    32'(cs_n0),  32'd1);
    check("rst_sdata",   32'(sdata0), 32'd0);
    check("rst_busy",    32'(busy0),  32'd0);
    check("rst_done",    32'(done0),  32'd0);
    check("rst_overrun", 32'(ovr0),   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Latency: capture edge N, LOAD in N+1, cs_n low from N+2
    send(0, 1'b1);
    check("busy_after_capture", 32'(busy0), 32'd1);
    check("cs_n_before_frame",  32'(cs_n0), 32'd1);
    @(negedge clk);
    check("cs_n_in_load",       32'(cs_n0), 32'd1);
    @(negedge clk);
    check("cs_n_first_shift",   32'(cs_n0), 32'd0);
    check("sclk_first_shift",   32'(sclk0), 32'd0);
    wait_idle();

    // Conversion patterns, one frame each
    for (int i = 1; i < 6; i++) begin
      send(i, 1'b1);
      wait_idle();
    end

    // Strobe during the LOAD cycle refills pending without overrun
    send(3, 1'b1);
    send(4, 1'b1);
    wait_idle();
    check("ovr_load_refill", 32'(ovr0), 32'd0);

    // Second sample mid-frame goes out back-to-back
    send(1, 1'b1);
    repeat (20) @(negedge clk);
    send(2, 1'b1);
    wait_idle();
    check("ovr_back_to_back", 32'(ovr0), 32'd0);

    // Third sample overwrites the pending one
    send(3, 1'b1);
    repeat (10) @(negedge clk);
    send(4, 1'b0);
    repeat (4) @(negedge clk);
    send(5, 1'b1);
    wait_idle();
    check("ovr_set",      32'(ovr0), 32'd1);
    check("ovr_set_ctrl", 32'(ovr1), 32'd1);

    // Reset around bit 7 with a sample pending
    send(0, 1'b1);
    repeat (10) @(negedge clk);
    send(2, 1'b1);
    repeat (18) @(negedge clk);
    check("mid_frame_cs_n", 32'(cs_n0), 32'd0);
    check("mid_frame_busy", 32'(busy0), 32'd1);
    frames_before = frames0;
    @(posedge clk);
    #1 rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    check("async_rst_cs_n",    32'(cs_n0), 32'd1);
    check("async_rst_sclk",    32'(sclk0), 32'd0);
    check("async_rst_busy",    32'(busy0), 32'd0);
    check("async_rst_overrun", 32'(ovr0),  32'd0);
    check("async_rst_cs_n1",   32'(cs_n1), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_cs_n", 32'(cs_n0), 32'd1);
      check("post_rst_sclk", 32'(sclk0), 32'd0);
      check("post_rst_busy", 32'(busy0), 32'd0);
    end
    repeat (60) @(negedge clk);
    check("no_frame_after_rst", 32'(frames0), 32'(frames_before));
    check("idle_after_rst",     32'(busy0),   32'd0);

    // Recovery after reset
    send(5, 1'b1);
    wait_idle();
    check("ovr_after_recovery", 32'(ovr0), 32'd0);

    check("frames_outstanding0", 32'(q0.size()), 32'd0);
    check("frames_outstanding1", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
